// File: rtl/button_conditioner.sv
// Pushbutton front end: 2-FF synchronizer, per-channel debounce, press/release pulses, pause toggle.
// Define AUTOREPEAT_EN to add per-channel auto-repeat press pulses while a button is held.
module button_conditioner #(
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int TOGGLE_IDX      = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               toggle_allow,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               toggle_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic             s1;
        logic             s2;
        logic             lvl;
        logic             prs;
        logic             rls;
        logic [CNT_W-1:0] cnt;
        logic             accept;
        logic             rpt_fire;

        assign accept = (s2 != lvl) && (cnt == CNT_LAST);

`ifdef AUTOREPEAT_EN
        logic [RPT_W-1:0] rpt_cnt;
        logic             rpt_phase;

        // A release being accepted on this edge wins over a repeat, so press and release never coincide
        assign rpt_fire = lvl && !accept &&
                          (rpt_cnt == (rpt_phase ? RPT_PERIOD_LAST : RPT_DELAY_LAST));

        always_ff @(posedge clk or negedge clr) begin
            if (!clr) begin
                rpt_cnt   <= '0;
                rpt_phase <= 1'b0;
            end else if (!lvl || accept) begin
                rpt_cnt   <= '0;
                rpt_phase <= 1'b0;
            end else if (rpt_fire) begin
                rpt_cnt   <= '0;
                rpt_phase <= 1'b1;
            end else begin
                rpt_cnt   <= rpt_cnt + 1'b1;
            end
        end
`else
        assign rpt_fire = 1'b0;
`endif

        always_ff @(posedge clk or negedge clr) begin
            if (!clr) begin
                s1  <= 1'b0;
                s2  <= 1'b0;
                lvl <= 1'b0;
                prs <= 1'b0;
                rls <= 1'b0;
                cnt <= '0;
            end else begin
                s1  <= btn_raw[i];
                s2  <= s1;
                prs <= (accept && s2) || rpt_fire;
                rls <= accept && !s2;
                if (s2 == lvl) begin
                    cnt <= '0;
                end else if (accept) begin
                    lvl <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign btn_level[i]   = lvl;
        assign btn_press[i]   = prs;
        assign btn_release[i] = rls;
    end

    // Forcing low while not allowed outranks any coincident press
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            toggle_out <= 1'b0;
        end else if (!toggle_allow) begin
            toggle_out <= 1'b0;
        end else if (btn_press[TOGGLE_IDX]) begin
            toggle_out <= ~toggle_out;
        end
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream front end for the game's pushbuttons (jump, pause/enable, restart).
- Each raw asynchronous button passes through a 2-FF synchronizer and a per-channel debounce counter.
- Produces clean levels plus single-cycle press/release pulses for the game-state logic and bird physics.
- Also owns the pause toggle flip-flop, so game control never sees raw button edges.

Parameters:
NUM_BTN, 3, number of button channels (bit 0 jump, bit 1 pause, bit 2 restart by convention)
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a new level (5 ms at 50 MHz); legal range 2..2^CNT_W-1
CNT_W, 18, width of each debounce counter
TOGGLE_IDX, 1, channel whose press events flip toggle_out
REPEAT_DELAY, 25000000, cycles held before first auto-repeat (AUTOREPEAT_EN only)
REPEAT_PERIOD, 5000000, cycles between auto-repeats (AUTOREPEAT_EN only)

Ports:
clk  input  1  system clock, all state on rising edge
clr  input  1  asynchronous, active-low reset
btn_raw  input  NUM_BTN  raw, asynchronous pushbutton inputs, active-high
toggle_allow  input  1  when 0, toggle_out is forced to 0 (e.g. game not in play state)
btn_level  output  NUM_BTN  debounced level per channel
btn_press  output  NUM_BTN  1-cycle pulse on accepted 0->1 transition (and on auto-repeat)
btn_release  output  NUM_BTN  1-cycle pulse on accepted 1->0 transition
toggle_out  output  1  pause flag, flips on each btn_press[TOGGLE_IDX]

Behaviour:
- Reset (clr=0, asynchronous): sync stages, counters, btn_level, btn_press, btn_release and toggle_out all 0. The first clk edge after deassertion operates normally.
- Synchronizer: per channel, s1 <= btn_raw and s2 <= s1. Only s2 is used downstream.
- Debounce, per channel, each edge:
  - If s2 == btn_level: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: btn_level <= s2, counter <= 0, and on the same edge btn_press (if s2=1) or btn_release (if s2=0) is registered high.
  - Else: counter <= counter+1.
- Any single-cycle return of s2 to btn_level restarts the count from 0 (glitch rejection).
- Latency: call the first edge that samples the new btn_raw value edge 1. btn_level changes, and the pulse is high, after edge DEBOUNCE_CYCLES+2. The pulse is high for exactly one cycle.
- btn_press and btn_release are never both high on one channel in the same cycle. Channels are fully independent; simultaneous transitions on several channels give simultaneous pulses.
- Toggle:
  - If toggle_allow==0: toggle_out <= 0. This has priority over a coincident press.
  - Else if btn_press[TOGGLE_IDX]: toggle_out <= ~toggle_out.
  - The update lands one cycle after the press pulse.
- Counter saturation cannot occur, since DEBOUNCE_CYCLES-1 < 2^CNT_W.
- Reset mid-count discards the partial count; no pulse is emitted on exit from reset even if btn_raw is held high. The level is accepted only after a full debounce from 0.

Optional Feature:
Macro AUTOREPEAT_EN.
- Defined: each channel has an extra repeat counter that runs while btn_level==1.
  - When held REPEAT_DELAY cycles after the accepted press, btn_press pulses once.
  - Further pulses follow every REPEAT_PERIOD cycles while still held.
  - Counter clears when btn_level falls or on reset.
  - Repeat pulses also drive the toggle logic.
- Not defined: no repeat counters exist and btn_press fires only on accepted edges.

Test Plan (DEBOUNCE_CYCLES=4, NUM_BTN=3, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Hold btn_raw=3'b000 through reset, release clr -> all outputs 0; raw held 0 for 20 cycles gives no pulses.
- btn_raw[0] 0->1 held -> btn_level[0]=1 and btn_press[0]=1 after edge 6 from first sampling, press low next cycle, channels 1/2 remain 0.
- btn_raw[0] bounces 1,0,1,0 each cycle for 8 cycles then stays 1 -> exactly one btn_press[0], 6 edges after the final stable 1; zero release pulses.
- toggle_allow=1, press/release channel 1 twice -> toggle_out goes 0->1->0, each change one cycle after btn_press[1]; drop toggle_allow to 0 coincident with a press -> toggle_out=0.
- Channel 2 mid-debounce (counter=2), assert clr=0 for 1 cycle -> all outputs 0 immediately; after release, level accepted only after a full 4-cycle stable count.
- With AUTOREPEAT_EN, hold channel 0 for 30 cycles after acceptance -> btn_press[0] pulses at +0, +10, +13, +16, ... +28; without the macro, a single pulse only.
